// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and multiply/divide unit.
//   alu_op codes (4 bits), md_op codes (3 bits), MDU state enum.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_t;
endpackage

// File: rtl/alu_mdu_core.sv
// Multiply/divide unit owning HI/LO.
//   clk, reset   : clock, synchronous active-high reset
//   a, b         : operands, sampled only on the accepting edge
//   md_start     : request strobe, accepted when not busy
//   md_op        : MDU function select
//   busy         : registered, high while a mult/div is in flight
//   hi, lo       : architectural HI/LO registers
module alu_mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_t          state, state_n;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pend, res;
  logic               accept, is_long, is_mul;

  assign busy    = (state == MD_RUN);
  assign accept  = md_start && !busy;
  assign is_mul  = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_long = is_mul || (md_op == MD_DIV) || (md_op == MD_DIVU);

  // Products: sign- or zero-extend to 2*WIDTH so the low 2*WIDTH bits are exact.
  logic [2*WIDTH-1:0] sprod, uprod;
  assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Divisor is forced to 1 in the special cases so the divider never sees
  // /0 or MIN/-1; those results come from the override mux below.
  logic             dz, dovf;
  logic [WIDTH-1:0] bsafe, uq, ur;
  logic signed [WIDTH-1:0] sq, sr;
  assign dz    = (b == '0);
  assign dovf  = (a == SMIN) && (b == '1);
  assign bsafe = (dz || dovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign sq    = $signed(a) / $signed(bsafe);
  assign sr    = $signed(a) % $signed(bsafe);
  assign uq    = a / bsafe;
  assign ur    = a % bsafe;

  always_comb begin
    res = '0;
    case (md_op)
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_DIV:   res = dz ? {a, {WIDTH{1'b1}}} :
                      dovf ? {{WIDTH{1'b0}}, SMIN} : {sr, sq};
      MD_DIVU:  res = dz ? {a, {WIDTH{1'b1}}} : {ur, uq};
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (md_start && is_long) state_n = MD_RUN;
      MD_RUN:  if (cnt == CW'(1)) state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (is_long) begin
          pend <= res;
          cnt  <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
        end
        if (md_op == MD_MTHI) hi <= a;
        if (md_op == MD_MTLO) lo <= a;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) {hi, lo} <= pend;
      end
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// EX-stage datapath: combinational ALU plus registered multiply/divide unit.
//   a, b, alu_op -> c, zero, overflow (combinational)
//   md_start, md_op -> busy, hi, lo (registered, see alu_mdu_core)
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sum, diff;
  assign shamt = b[SW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    c        = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        c        = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        c        = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_SRL:  c = a >> shamt;
      ALU_SRA:  c = $signed(a) >>> shamt;
      ALU_XOR:  c = a ^ b;
      ALU_NOR:  c = ~(a | b);
      ALU_SLL:  c = a << shamt;
      ALU_SLT:  c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: c = {{(WIDTH-1){1'b0}}, a < b};
      default:  c = '0;
    endcase
  end

  assign zero = (c == '0);

  alu_mdu_core #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_core (
    .clk(clk), .reset(reset), .a(a), .b(b), .md_start(md_start), .md_op(md_op),
    .busy(busy), .hi(hi), .lo(lo)
  );
endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance, default latencies
  logic [31:0] a, b, c, hi, lo;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic        zero, overflow, md_start, busy;

  // 16-bit instance, single-cycle latencies
  logic [15:0] a2, b2, c2, hi2, lo2;
  logic [3:0]  alu_op2;
  logic [2:0]  md_op2;
  logic        zero2, overflow2, md_start2, busy2;

  int n_run = 0, n_fail = 0;

  alu_mdu dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alu_op(alu_op), .c(c), .zero(zero),
    .overflow(overflow), .md_start(md_start), .md_op(md_op), .busy(busy), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut16 (
    .clk(clk), .reset(reset), .a(a2), .b(b2), .alu_op(alu_op2), .c(c2), .zero(zero2),
    .overflow(overflow2), .md_start(md_start2), .md_op(md_op2), .busy(busy2), .hi(hi2), .lo(lo2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    alu_op = op; a = va; b = vb;
    #1;
  endtask

  task automatic alu16(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
    alu_op2 = op; a2 = va; b2 = vb;
    #1;
  endtask

  // Issue a 32-bit mult/div, wait out N busy cycles, then check result.
  task automatic md32(input string tag, input logic [2:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input int ncyc,
                      input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] ohi, olo;
    ohi = hi; olo = lo;
    a = va; b = vb; md_op = op; md_start = 1'b1;
    step();
    md_start = 1'b0; a = 32'h5A5A_5A5A; b = 32'h0000_0003;
    for (int i = 1; i <= ncyc; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_hold"}, {hi, lo}, {ohi, olo});
      step();
    end
    chk({tag, "_done"}, busy, 1'b0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  task automatic md16(input string tag, input logic [2:0] op, input logic [15:0] va,
                      input logic [15:0] vb, input logic [15:0] ehi, input logic [15:0] elo);
    a2 = va; b2 = vb; md_op2 = op; md_start2 = 1'b1;
    step();
    md_start2 = 1'b0; a2 = 16'h00FF;
    chk({tag, "_busy"}, busy2, 1'b1);
    step();
    chk({tag, "_done"}, busy2, 1'b0);
    chk({tag, "_hi"}, hi2, ehi);
    chk({tag, "_lo"}, lo2, elo);
  endtask

  initial begin
    a = '0; b = '0; alu_op = '0; md_op = '0; md_start = 1'b0;
    a2 = '0; b2 = '0; alu_op2 = '0; md_op2 = '0; md_start2 = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst16_hilo", {busy2, hi2, lo2}, 33'd0);

    // ALU, WIDTH=32
    alu(4'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_c", c, 32'h8000_0000); chk("add_ovf", overflow, 1'b1);
    alu(4'd0, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap", {c, zero, overflow}, {32'h0, 1'b1, 1'b0});
    alu(4'd1, 32'd5, 32'd5);
    chk("sub_c", c, 32'd0); chk("sub_zero", zero, 1'b1);
    alu(4'd1, 32'h8000_0000, 32'd1);
    chk("sub_ovf", {c, overflow}, {32'h7FFF_FFFF, 1'b1});
    alu(4'd2, 32'hF0F0_FFFF, 32'h0FF0_00FF); chk("and", c, 32'h00F0_00FF);
    alu(4'd3, 32'hF000_0001, 32'h0F00_0010); chk("or", c, 32'hFF00_0011);
    alu(4'd4, 32'h8000_0000, 32'h24);        chk("srl", c, 32'h0800_0000);
    alu(4'd5, 32'h8000_0000, 32'h24);        chk("sra", c, 32'hF800_0000);
    alu(4'd6, 32'hFF00_FF00, 32'h0FF0_0FF0); chk("xor", c, 32'hF0F0_F0F0);
    alu(4'd7, 32'hFF00_0000, 32'h00FF_0000);
    chk("nor", {c, overflow}, {32'h0000_FFFF, 1'b0});
    alu(4'd8, 32'h0000_0003, 32'hFFFF_FFE1); chk("sll_amt1", c, 32'h0000_0006);
    alu(4'd9, 32'hFFFF_FFFF, 32'd1);         chk("slt", c, 32'd1);
    alu(4'd10, 32'hFFFF_FFFF, 32'd1);        chk("sltu_ge", c, 32'd0);
    alu(4'd10, 32'd1, 32'hFFFF_FFFF);        chk("sltu", c, 32'd1);
    alu(4'd12, 32'h1234_5678, 32'h1);        chk("op12", {c, zero}, {32'd0, 1'b1});

    // mthi when idle
    step();
    a = 32'h1234; md_op = 3'd4; md_start = 1'b1;
    step();
    md_start = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", busy, 1'b0);

    md32("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md32("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md32("divu0", 3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
    md32("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    md32("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // mtlo while busy from multu is dropped
    a = 32'hFFFF_FFFF; b = 32'd2; md_op = 3'd1; md_start = 1'b1;
    step();
    a = 32'h0000_DEAD; md_op = 3'd5; md_start = 1'b1;
    step();
    md_start = 1'b0;
    step(); step(); step(); step();
    chk("multu_done", busy, 1'b0);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    // reset in cycle t+3 of a div
    a = 32'd100; b = 32'd3; md_op = 3'd2; md_start = 1'b1;
    step();
    md_start = 1'b0;
    step(); step();
    chk("rstmid_busy_pre", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 12; i++) step();
    chk("rstmid_never", {busy, hi, lo}, 65'd0);

    // WIDTH=16, single-cycle MDU
    alu16(4'd0, 16'h7FFF, 16'h1);
    chk("add16", {c2, overflow2}, {16'h8000, 1'b1});
    alu16(4'd1, 16'd5, 16'd5);
    chk("sub16", {c2, zero2}, {16'h0, 1'b1});
    alu16(4'd5, 16'h8000, 16'h14);          chk("sra16", c2, 16'hF800);
    alu16(4'd10, 16'd1, 16'hFFFF);          chk("sltu16", c2, 16'd1);
    step();
    md16("mult16", 3'd0, 16'hFFFD, 16'd7, 16'hFFFF, 16'hFFEB);
    md16("div16", 3'd2, 16'hFFF9, 16'd2, 16'hFFFF, 16'hFFFD);
    md16("divu016", 3'd3, 16'd7, 16'd0, 16'd7, 16'hFFFF);
    md16("divovf16", 3'd2, 16'h8000, 16'hFFFF, 16'h0, 16'h8000);
    a2 = 16'h1234; md_op2 = 3'd4; md_start2 = 1'b1;
    step();
    md_start2 = 1'b0;
    chk("mthi16", {busy2, hi2}, {1'b0, 16'h1234});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
